// File: rtl/reduce_frame_feeder.sv
// Buffers a ready/valid word stream and replays it as fixed-length frames
// separated by a forced idle gap, for a reducer that has no backpressure.
module reduce_frame_feeder #(
    parameter int FIFO_DEPTH = 16,
    parameter int FRAME_LEN  = 1024,
    parameter int GAP_CYCLES = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          flush,
    input  logic                          en,
    input  logic [31:0]                   s_data,
    input  logic                          s_valid,
    output logic                          s_ready,
    output logic [31:0]                   out_data,
    output logic                          out_valid,
    output logic                          frame_last,
    output logic [15:0]                   frame_count,
    output logic [$clog2(FIFO_DEPTH):0]   fill_level
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [CW-1:0] LAST_IDX = CW'(FRAME_LEN - 1);
    localparam logic [GW-1:0] GAP_LAST = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam logic [AW:0]   FULL     = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, RUN, GAP} state_t;

    logic [31:0]   mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] word_cnt;
    logic [GW-1:0] gap_cnt;
    state_t        state;
    logic          push;
    logic          pop;
    logic          last_word;

    // Ready depends only on registered occupancy, so a pop never opens a full FIFO early.
    assign s_ready   = (fill_level != FULL);
    assign push      = s_valid & s_ready & ~flush;
    assign pop       = (state == RUN) & en & (fill_level != '0) & ~flush;
    assign last_word = (word_cnt == LAST_IDX);

    // NOTE: the storage array has no reset; an entry is only read after it has been written.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= s_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fill_level <= '0;
        end else if (flush) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fill_level <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   fill_level <= fill_level + 1'b1;
                2'b01:   fill_level <= fill_level - 1'b1;
                default: fill_level <= fill_level;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            word_cnt    <= '0;
            gap_cnt     <= '0;
            out_data    <= '0;
            out_valid   <= 1'b0;
            frame_last  <= 1'b0;
            frame_count <= '0;
        end else if (flush) begin
            state      <= IDLE;
            word_cnt   <= '0;
            gap_cnt    <= '0;
            out_valid  <= 1'b0;
            frame_last <= 1'b0;
        end else begin
            out_valid  <= 1'b0;
            frame_last <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (en) state <= RUN;
                end
                RUN: begin
                    if (!en) begin
                        state <= IDLE;
                    end else if (pop) begin
                        out_data   <= mem[rd_ptr];
                        out_valid  <= 1'b1;
                        frame_last <= last_word;
                        if (last_word) begin
                            word_cnt    <= '0;
                            frame_count <= frame_count + 1'b1;
                            if (GAP_CYCLES > 0) begin
                                state   <= GAP;
                                gap_cnt <= '0;
                            end
                        end else begin
                            word_cnt <= word_cnt + 1'b1;
                        end
                    end
                end
                GAP: begin
                    // Holds for exactly GAP_CYCLES edges, then resumes or parks.
                    if (gap_cnt == GAP_LAST) begin
                        state <= en ? RUN : IDLE;
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_reduce_frame_feeder.sv
// Self-checking bench for reduce_frame_feeder: vector table, directed corner
// sequences and a randomized run against a queue-based frame model.
module tb_reduce_frame_feeder;

    localparam int FD = 4;
    localparam int FL = 4;
    localparam int GC = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        en;
    logic [31:0] s_data;
    logic        s_valid;
    logic        s_ready;
    logic [31:0] out_data;
    logic        out_valid;
    logic        frame_last;
    logic [15:0] frame_count;
    logic [2:0]  fill_level;

    int total = 0;
    int bad   = 0;

    reduce_frame_feeder #(
        .FIFO_DEPTH(FD),
        .FRAME_LEN (FL),
        .GAP_CYCLES(GC)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .en         (en),
        .s_data     (s_data),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .frame_last (frame_last),
        .frame_count(frame_count),
        .fill_level (fill_level)
    );

    always #5 clk = ~clk;

    typedef struct {
        int en;
        int sv;
        int d;
        int ev;
        int ed;
        int el;
        int ef;
        int ec;
    } vec_t;

    vec_t vecs[14];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst     = 1'b1;
        flush   = 1'b0;
        en      = 1'b0;
        s_valid = 1'b0;
        s_data  = '0;
        step();
        step();
        rst = 1'b0;
        step();
    endtask

    task automatic push(input logic [31:0] d);
        s_valid = 1'b1;
        s_data  = d;
        step();
        s_valid = 1'b0;
    endtask

    // Waits (bounded) for the next valid word, checks it, then moves past it.
    task automatic expect_word(input string name, input logic [31:0] d, input logic last);
        int n = 0;
        while (!out_valid && n < 12) begin
            step();
            n++;
        end
        check({name, "_valid"}, 32'(out_valid), 1);
        check({name, "_data"}, out_data, d);
        check({name, "_last"}, 32'(frame_last), 32'(last));
        step();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] q[$];
        logic [31:0] exp_word;
        logic [31:0] last_data;
        int mfill, mn, mframe, gap_left;
        logic en_i, sv_i, fl_i;
        logic [31:0] d_i;
        bit acc;

        // Reset state
        do_reset();
        check("rst_valid", 32'(out_valid), 0);
        check("rst_data", out_data, 0);
        check("rst_last", 32'(frame_last), 0);
        check("rst_count", 32'(frame_count), 0);
        check("rst_fill", 32'(fill_level), 0);
        check("rst_ready", 32'(s_ready), 1);

        // Frame + gap: FSM first moved to RUN, then 8 words streamed back-to-back
        vecs[0]  = '{1, 1, 1, 0, 0, 0, 1, 0};
        vecs[1]  = '{1, 1, 2, 1, 1, 0, 1, 0};
        vecs[2]  = '{1, 1, 3, 1, 2, 0, 1, 0};
        vecs[3]  = '{1, 1, 4, 1, 3, 0, 1, 0};
        vecs[4]  = '{1, 1, 5, 1, 4, 1, 1, 1};
        vecs[5]  = '{1, 1, 6, 0, 4, 0, 2, 1};
        vecs[6]  = '{1, 1, 7, 0, 4, 0, 3, 1};
        vecs[7]  = '{1, 1, 8, 1, 5, 0, 3, 1};
        vecs[8]  = '{1, 0, 0, 1, 6, 0, 2, 1};
        vecs[9]  = '{1, 0, 0, 1, 7, 0, 1, 1};
        vecs[10] = '{1, 0, 0, 1, 8, 1, 0, 2};
        vecs[11] = '{1, 0, 0, 0, 8, 0, 0, 2};
        vecs[12] = '{1, 0, 0, 0, 8, 0, 0, 2};
        vecs[13] = '{1, 0, 0, 0, 8, 0, 0, 2};
        en = 1'b1;
        step();
        for (int i = 0; i < 14; i++) begin
            en      = vecs[i].en[0];
            s_valid = vecs[i].sv[0];
            s_data  = vecs[i].d;
            step();
            check($sformatf("vec%0d_valid", i), 32'(out_valid), vecs[i].ev);
            check($sformatf("vec%0d_data", i), out_data, vecs[i].ed);
            check($sformatf("vec%0d_last", i), 32'(frame_last), vecs[i].el);
            check($sformatf("vec%0d_fill", i), 32'(fill_level), vecs[i].ef);
            check($sformatf("vec%0d_count", i), 32'(frame_count), vecs[i].ec);
            check($sformatf("vec%0d_ready", i), 32'(s_ready), 32'(vecs[i].ef != FD));
        end
        s_valid = 1'b0;
        en      = 1'b0;

        // Mid-cycle asynchronous reset clears outputs without waiting for an edge
        #3;
        rst = 1'b1;
        #1;
        check("arst_valid", 32'(out_valid), 0);
        check("arst_data", out_data, 0);
        check("arst_count", 32'(frame_count), 0);
        check("arst_fill", 32'(fill_level), 0);
        step();
        rst = 1'b0;
        step();
        check("arst_ready", 32'(s_ready), 1);

        // Idle with 4 words buffered, then full boundary
        for (int i = 0; i < 4; i++) push(32'hA1 + 32'(i));
        check("full_fill", 32'(fill_level), 4);
        check("full_ready", 32'(s_ready), 0);
        for (int i = 0; i < 3; i++) begin
            step();
            check("idle_valid", 32'(out_valid), 0);
        end
        s_valid = 1'b1;
        s_data  = 32'hA5;
        step();
        check("full_5th_fill", 32'(fill_level), 4);
        en = 1'b1;
        step();
        check("full_run_ready", 32'(s_ready), 0);
        check("full_run_valid", 32'(out_valid), 0);
        step();
        check("full_pop_valid", 32'(out_valid), 1);
        check("full_pop_data", out_data, 32'hA1);
        check("full_pop_fill", 32'(fill_level), 3);
        check("full_pop_ready", 32'(s_ready), 1);
        s_valid = 1'b0;
        expect_word("full_w1", 32'hA1, 1'b0);
        expect_word("full_w2", 32'hA2, 1'b0);
        expect_word("full_w3", 32'hA3, 1'b0);
        expect_word("full_w4", 32'hA4, 1'b1);
        check("full_count", 32'(frame_count), 1);
        for (int i = 0; i < 3; i++) begin
            step();
            check("full_after_valid", 32'(out_valid), 0);
            check("full_after_fill", 32'(fill_level), 0);
        end

        // Bubble and pause: counter survives both
        do_reset();
        en = 1'b1;
        step();
        push(32'hB1);
        push(32'hB2);
        expect_word("bub_w1", 32'hB1, 1'b0);
        expect_word("bub_w2", 32'hB2, 1'b0);
        check("bub_gap0", 32'(out_valid), 0);
        step();
        check("bub_gap1", 32'(out_valid), 0);
        push(32'hB3);
        expect_word("bub_w3", 32'hB3, 1'b0);
        en = 1'b0;
        push(32'hB4);
        for (int i = 0; i < 2; i++) begin
            step();
            check("pause_valid", 32'(out_valid), 0);
            check("pause_fill", 32'(fill_level), 1);
        end
        en = 1'b1;
        expect_word("bub_w4", 32'hB4, 1'b1);
        check("bub_count", 32'(frame_count), 1);

        // Flush mid-frame while words are buffered and s_valid is high
        do_reset();
        en = 1'b1;
        step();
        for (int i = 0; i < 4; i++) push(32'hE1 + 32'(i));
        for (int i = 0; i < 3; i++) push(32'hF1 + 32'(i));
        for (int i = 0; i < 8; i++) begin
            if (out_valid && out_data == 32'hF2) break;
            step();
        end
        check("fl_reach", out_data, 32'hF2);
        flush   = 1'b1;
        s_valid = 1'b1;
        s_data  = 32'hF4;
        step();
        flush   = 1'b0;
        s_valid = 1'b0;
        en      = 1'b0;
        check("fl_fill", 32'(fill_level), 0);
        check("fl_valid", 32'(out_valid), 0);
        check("fl_last", 32'(frame_last), 0);
        check("fl_count", 32'(frame_count), 1);
        for (int i = 0; i < 4; i++) push(32'hC1 + 32'(i));
        check("fl_refill", 32'(fill_level), 4);
        en = 1'b1;
        expect_word("fl_w1", 32'hC1, 1'b0);
        expect_word("fl_w2", 32'hC2, 1'b0);
        expect_word("fl_w3", 32'hC3, 1'b0);
        expect_word("fl_w4", 32'hC4, 1'b1);
        check("fl_count2", 32'(frame_count), 2);

        // frame_count wrap
        do_reset();
        force dut.frame_count = 16'hFFFF;
        #1;
        release dut.frame_count;
        for (int i = 0; i < 4; i++) push(32'hD1 + 32'(i));
        en = 1'b1;
        expect_word("wrap_w1", 32'hD1, 1'b0);
        expect_word("wrap_w2", 32'hD2, 1'b0);
        expect_word("wrap_w3", 32'hD3, 1'b0);
        expect_word("wrap_w4", 32'hD4, 1'b1);
        check("wrap_count", 32'(frame_count), 0);

        // Randomized run: words must come out in order, framed every FL words
        do_reset();
        q.delete();
        mfill     = 0;
        mn        = 0;
        mframe    = 0;
        gap_left  = 0;
        last_data = '0;
        for (int cyc = 0; cyc < 700; cyc++) begin
            en_i = (cyc >= 600) ? 1'b1 : ($urandom % 8 != 0);
            sv_i = (cyc >= 600) ? 1'b0 : ($urandom % 3 != 0);
            fl_i = (cyc < 600) && ($urandom % 80 == 0);
            d_i  = $urandom;
            en      = en_i;
            s_valid = sv_i;
            flush   = fl_i;
            s_data  = d_i;
            check("rnd_ready", 32'(s_ready), 32'(mfill != FD));
            acc = sv_i && !fl_i && (mfill != FD);
            step();
            if (fl_i) begin
                q.delete();
                mfill    = 0;
                mn       = 0;
                gap_left = 0;
                check("rnd_fl_valid", 32'(out_valid), 0);
                check("rnd_fl_last", 32'(frame_last), 0);
            end else begin
                if (!en_i) check("rnd_pause", 32'(out_valid), 0);
                if (gap_left > 0) begin
                    check("rnd_gap", 32'(out_valid), 0);
                    gap_left--;
                end
                if (out_valid) begin
                    if (q.size() == 0) begin
                        check("rnd_spurious", 32'(out_valid), 0);
                    end else begin
                        exp_word = q.pop_front();
                        mfill--;
                        check("rnd_data", out_data, exp_word);
                        check("rnd_last", 32'(frame_last), 32'(mn == FL - 1));
                        last_data = exp_word;
                        if (mn == FL - 1) begin
                            mn       = 0;
                            mframe   = (mframe + 1) % 65536;
                            gap_left = GC;
                        end else begin
                            mn++;
                        end
                    end
                end else begin
                    check("rnd_hold", out_data, last_data);
                    check("rnd_last_idle", 32'(frame_last), 0);
                end
                if (acc) begin
                    q.push_back(d_i);
                    mfill++;
                end
            end
            check("rnd_fill", 32'(fill_level), mfill);
            check("rnd_count", 32'(frame_count), mframe);
        end
        flush   = 1'b0;
        s_valid = 1'b0;
        check("rnd_drain_fill", 32'(fill_level), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/reduce_frame_feeder.md
Name: reduce_frame_feeder

Overview:
- Upstream stage for the reduce_sum accumulator.
- Accepts a ready/valid 32-bit word stream and buffers it in a FIFO.
- Replays the words as a paced in_data/in_valid stream, cut into frames of exactly FRAME_LEN words, with an enforced idle gap between frames.
- The gap keeps the reducer's count aligned to frame boundaries; the reducer itself has no backpressure.

Parameters:
FIFO_DEPTH, 16, buffer entries; power of two, >=2
FRAME_LEN, 1024, words per frame; must equal the reducer's BUFFER_DEPTH
GAP_CYCLES, 2, forced out_valid-low cycles after each frame; 0 = no gap state

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  reset, asynchronous, active-high
flush  in  1  synchronous clear of FIFO, counters and FSM
en  in  1  drain enable; low pauses emission
s_data  in  32  upstream word
s_valid  in  1  upstream word valid
s_ready  out  1  feeder can accept (FIFO not full)
out_data  out  32  word to reducer (drives its in_data)
out_valid  out  1  word valid (drives its in_valid)
frame_last  out  1  high with the last word of a frame
frame_count  out  16  completed frames, wraps at 65535->0
fill_level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy

Behaviour:
- Reset (async assert, sync-safe deassert) values:
  - out_data=0, out_valid=0, frame_last=0, frame_count=0, fill_level=0.
  - FIFO empty, word counter=0, FSM=IDLE.
  - s_ready=1 once rst is low.
- s_ready = (fill_level != FIFO_DEPTH). Combinational from registered occupancy only.
- Write occurs on an edge with s_valid & s_ready.
- When the FIFO is full, a same-cycle read does NOT open s_ready. No write-through.
- FIFO read/write pointers wrap modulo FIFO_DEPTH. fill_level updates +1 on write only, -1 on read only, and is unchanged on simultaneous read+write.
- FSM states:
  - IDLE: out_valid=0. Go to RUN when en=1.
  - RUN: on each edge with en=1 and FIFO non-empty, pop one word into out_data and set out_valid=1 for the next cycle. Otherwise out_valid=0 next cycle (bubble); the reducer tolerates bubbles. The word counter increments per pop.
  - Last pop of a frame (counter==FRAME_LEN-1):
    - frame_last=1 alongside that word.
    - counter->0, frame_count+1.
    - Go to GAP if GAP_CYCLES>0, else stay in RUN.
  - GAP: out_valid=0, no pops, for exactly GAP_CYCLES cycles. Then RUN if en=1, else IDLE.
  - en=0 in RUN: go to IDLE next edge. The counter is retained, so the frame resumes mid-way.
- Latency: a word written on edge E can be popped at edge E+1 at the earliest. out_valid is high during the cycle after E+1 (2-edge fall-through).
- out_data holds its last value while out_valid=0.
- frame_last is high only in cycles where out_valid=1.
- Output registers are loaded only from FIFO contents. No combinational path from s_data to out_data.
- flush:
  - Priority over everything except rst.
  - Next edge: FIFO empty, counter=0, out_valid=0, frame_last=0, FSM=IDLE.
  - frame_count is kept.
  - s_valid during the flush cycle is dropped.
- frame_count wraps 65535->0 silently.
- Counter width is $clog2(FRAME_LEN); FRAME_LEN=1 makes every word frame_last.

Test Plan:
- All tests use FIFO_DEPTH=4, FRAME_LEN=4, GAP_CYCLES=2.
- Reset/idle:
  - Stimulus: assert rst mid-cycle.
  - Required: outputs zero immediately, s_ready=1 after release, out_valid stays 0 with en=0 and 4 words buffered; fill_level=4, s_ready=0.
- Frame + gap:
  - Stimulus: en=1, stream 8 words 1..8 continuously.
  - Required: out_valid pattern 1111 00 1111; frame_last on words 4 and 8; frame_count=2; first out_valid exactly 2 edges after the first accept.
- Full boundary:
  - Stimulus: en=0, write 5 words.
  - Required: only 4 accepted, s_ready=0 on the 5th. Then en=1: s_ready rises one cycle after the first pop, never in the pop cycle.
- Bubble/pause:
  - Stimulus: stall s_valid after word 2, then drop en after word 3.
  - Required: out_valid gaps, counter retained; the resumed word 4 carries frame_last.
- Flush mid-frame:
  - Stimulus: after word 2 of frame 1 has been output, pulse flush while words are buffered and s_valid=1.
  - Required: fill_level=0, out_valid=0 next cycle, frame_count unchanged. The next frame restarts counting at 0 (frame_last on its 4th word).
- Wrap: force frame_count to 65535, complete one frame -> frame_count=0.
